// File: rtl/dnn_result_collector.sv
// dnn_result_collector
// Downstream stage of the 4-4-2 DNN core. It pairs the two output-neuron values
// (out0 from neuron 8, out1 from neuron 9). The two values may arrive on different
// cycles. Each completed pair is classified by argmax and queued in a small FIFO,
// and a consumer drains the FIFO with a valid/ready handshake.
//
// Ports
//   clk, rst_n               clock (rising edge), asynchronous active-low reset
//   out0/out0_ready          neuron-8 value and its single-cycle capture strobe
//   out1/out1_ready          neuron-9 value and its single-cycle capture strobe
//   res_valid/res_ready      FIFO head handshake
//   res_class                0: out0 >= out1, 1: out1 > out0 (head pair)
//   res_score0/res_score1    head pair values
//   res_margin               head out0 - out1, 18 bits
//   res_count                FIFO occupancy, 0..DEPTH
//   busy                     a pair is half-captured
//   timeout_err              sticky: half pair discarded because its partner never came
//   overflow                 sticky: completed pair dropped because the FIFO was full
//   clr_err                  synchronous clear of both sticky flags
module dnn_result_collector #(
    parameter int DEPTH      = 4,
    parameter int TIMEOUT    = 64,
    parameter bit SIGNED_OUT = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [16:0]               out0,
    input  logic [16:0]               out1,
    input  logic                      out0_ready,
    input  logic                      out1_ready,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic                      res_class,
    output logic [16:0]               res_score0,
    output logic [16:0]               res_score1,
    output logic [17:0]               res_margin,
    output logic [$clog2(DEPTH):0]    res_count,
    output logic                      busy,
    output logic                      timeout_err,
    output logic                      overflow,
    input  logic                      clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CFULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HAVE0,
        S_HAVE1
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [TW-1:0]   r_timer;
    logic [TW-1:0]   w_nextTimer;
    logic [16:0]     r_lat0;
    logic [16:0]     r_lat1;
    logic            w_load0;
    logic            w_load1;
    logic            w_push;
    logic [16:0]     w_pushD0;
    logic [16:0]     w_pushD1;
    logic            w_timeoutEv;

    logic [16:0]     r_mem0 [DEPTH];
    logic [16:0]     r_mem1 [DEPTH];
    logic [AW-1:0]   r_wrPtr;
    logic [AW-1:0]   r_rdPtr;
    logic [CW-1:0]   r_count;
    logic [16:0]     r_last0;
    logic [16:0]     r_last1;
    logic            r_timeoutErr;
    logic            r_overflow;

    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_doPush;
    logic            w_overflowEv;
    logic [16:0]     w_head0;
    logic [16:0]     w_head1;
    logic [17:0]     w_ext0;
    logic [17:0]     w_ext1;

    // Pairing FSM: state, timer and the latched half of a pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_lat0  <= '0;
            r_lat1  <= '0;
        end else begin
            r_state <= w_nextState;
            r_timer <= w_nextTimer;
            if (w_load0) r_lat0 <= out0;
            if (w_load1) r_lat1 <= out1;
        end
    end

    // Next-state logic. When a partner strobe completes a pair while the waiting
    // side also strobes again, the new value starts the next pair.
    // A partner strobe on the final timer cycle is checked first, so it wins.
    always_comb begin
        w_nextState = r_state;
        w_nextTimer = '0;
        w_load0     = 1'b0;
        w_load1     = 1'b0;
        w_push      = 1'b0;
        w_pushD0    = out0;
        w_pushD1    = out1;
        w_timeoutEv = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (out0_ready && out1_ready) begin
                    w_push = 1'b1;
                end else if (out0_ready) begin
                    w_load0     = 1'b1;
                    w_nextState = S_HAVE0;
                end else if (out1_ready) begin
                    w_load1     = 1'b1;
                    w_nextState = S_HAVE1;
                end
            end
            S_HAVE0: begin
                w_pushD0 = r_lat0;
                if (out1_ready) begin
                    w_push = 1'b1;
                    if (out0_ready) begin
                        w_load0 = 1'b1;
                    end else begin
                        w_nextState = S_IDLE;
                    end
                end else if (out0_ready) begin
                    w_load0 = 1'b1;
                end else if (r_timer == TMAX) begin
                    w_timeoutEv = 1'b1;
                    w_nextState = S_IDLE;
                end else begin
                    w_nextTimer = r_timer + 1'b1;
                end
            end
            S_HAVE1: begin
                w_pushD1 = r_lat1;
                if (out0_ready) begin
                    w_push = 1'b1;
                    if (out1_ready) begin
                        w_load1 = 1'b1;
                    end else begin
                        w_nextState = S_IDLE;
                    end
                end else if (out1_ready) begin
                    w_load1 = 1'b1;
                end else if (r_timer == TMAX) begin
                    w_timeoutEv = 1'b1;
                    w_nextState = S_IDLE;
                end else begin
                    w_nextTimer = r_timer + 1'b1;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == CFULL);
    assign w_pop        = !w_empty && res_ready;
    // A pop on the same edge frees the slot, so a push into a full FIFO still succeeds.
    assign w_doPush     = w_push && (!w_full || w_pop);
    assign w_overflowEv = w_push && w_full && !w_pop;

    // FIFO storage. When full with a simultaneous pop, the write slot equals the
    // departing head slot, which is safe because the head moves on at the same edge.
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem0[r_wrPtr] <= w_pushD0;
            r_mem1[r_wrPtr] <= w_pushD1;
        end
    end

    // FIFO pointers, occupancy, the last popped pair and the sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr      <= '0;
            r_rdPtr      <= '0;
            r_count      <= '0;
            r_last0      <= '0;
            r_last1      <= '0;
            r_timeoutErr <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
                r_last0 <= r_mem0[r_rdPtr];
                r_last1 <= r_mem1[r_rdPtr];
            end
            if (w_doPush && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_doPush && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (w_timeoutEv) begin
                r_timeoutErr <= 1'b1;
            end else if (clr_err) begin
                r_timeoutErr <= 1'b0;
            end
            if (w_overflowEv) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // While the FIFO is empty the outputs keep showing the last popped pair.
    // The FIFO memory is only read when it holds valid entries.
    assign w_head0 = w_empty ? r_last0 : r_mem0[r_rdPtr];
    assign w_head1 = w_empty ? r_last1 : r_mem1[r_rdPtr];

    // The 18-bit difference of two extended 17-bit values cannot overflow.
    // Its sign bit is therefore exactly "out1 > out0", and a tie gives class 0.
    assign w_ext0 = SIGNED_OUT ? {w_head0[16], w_head0} : {1'b0, w_head0};
    assign w_ext1 = SIGNED_OUT ? {w_head1[16], w_head1} : {1'b0, w_head1};

    assign res_margin  = w_ext0 - w_ext1;
    assign res_class   = res_margin[17];
    assign res_score0  = w_head0;
    assign res_score1  = w_head1;
    assign res_valid   = !w_empty;
    assign res_count   = r_count;
    assign busy        = (r_state != S_IDLE);
    assign timeout_err = r_timeoutErr;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_dnn_result_collector.sv
// Testbench for dnn_result_collector (DEPTH=4, TIMEOUT=64).
// The main instance uses signed outputs. A second instance with unsigned outputs
// covers the unsigned argmax case. Inputs change 1 time unit after a rising edge,
// and outputs are sampled at that same point.
module tb_dnn_result_collector;

    logic        clk;
    logic        rst_n;
    logic [16:0] out0, out1;
    logic        out0_ready, out1_ready, res_ready, clr_err;
    logic        res_valid, res_class, busy, timeout_err, overflow;
    logic [16:0] res_score0, res_score1;
    logic [17:0] res_margin;
    logic [2:0]  res_count;

    logic [16:0] uOut0, uOut1;
    logic        uOut0Ready, uOut1Ready;
    logic        uValid, uClass, uBusy, uTmo, uOvf;
    logic [16:0] uScore0, uScore1;
    logic [17:0] uMargin;
    logic [2:0]  uCount;

    int nChecks = 0;
    int nFails  = 0;

    dnn_result_collector #(.DEPTH(4), .TIMEOUT(64), .SIGNED_OUT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .out0(out0), .out1(out1),
        .out0_ready(out0_ready), .out1_ready(out1_ready),
        .res_valid(res_valid), .res_ready(res_ready), .res_class(res_class),
        .res_score0(res_score0), .res_score1(res_score1), .res_margin(res_margin),
        .res_count(res_count), .busy(busy), .timeout_err(timeout_err),
        .overflow(overflow), .clr_err(clr_err)
    );

    dnn_result_collector #(.DEPTH(4), .TIMEOUT(64), .SIGNED_OUT(1'b0)) dutUnsigned (
        .clk(clk), .rst_n(rst_n), .out0(uOut0), .out1(uOut1),
        .out0_ready(uOut0Ready), .out1_ready(uOut1Ready),
        .res_valid(uValid), .res_ready(1'b0), .res_class(uClass),
        .res_score0(uScore0), .res_score1(uScore1), .res_margin(uMargin),
        .res_count(uCount), .busy(uBusy), .timeout_err(uTmo),
        .overflow(uOvf), .clr_err(1'b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one cycle of inputs through a rising edge, then drops the strobes.
    task automatic applyStimulus(input logic [16:0] v0, input logic [16:0] v1,
                                 input logic s0, input logic s1, input logic rr);
        out0 = v0; out1 = v1; out0_ready = s0; out1_ready = s1; res_ready = rr;
        @(posedge clk); #1;
        out0_ready = 1'b0; out1_ready = 1'b0; res_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nChecks++; if (res_valid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_valid: got %0b expected 0", res_valid); end
        nChecks++; if (res_count !== 3'd0) begin nFails++; $display("[TB] FAIL reset_count: got %0d expected 0", res_count); end
        nChecks++; if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
        nChecks++; if ({timeout_err, overflow} !== 2'b00) begin nFails++; $display("[TB] FAIL reset_flags: got %b expected 00", {timeout_err, overflow}); end
        nChecks++; if (res_score0 !== 17'd0 || res_score1 !== 17'd0 || res_margin !== 18'd0) begin
            nFails++; $display("[TB] FAIL reset_data: got %h/%h/%h expected 0", res_score0, res_score1, res_margin); end
        rst_n = 1'b1;
        applyStimulus(17'd0, 17'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_same_cycle;
        applyStimulus(17'd100, 17'h1FFEC, 1'b1, 1'b1, 1'b0);
        nChecks++; if (res_valid !== 1'b1) begin nFails++; $display("[TB] FAIL t1_valid: got %0b expected 1", res_valid); end
        nChecks++; if (res_class !== 1'b0) begin nFails++; $display("[TB] FAIL t1_class: got %0b expected 0", res_class); end
        nChecks++; if (res_margin !== 18'd120) begin nFails++; $display("[TB] FAIL t1_margin: got %h expected %h", res_margin, 18'd120); end
        nChecks++; if (res_score1 !== 17'h1FFEC) begin nFails++; $display("[TB] FAIL t1_score1: got %h expected 1ffec", res_score1); end
        nChecks++; if (res_count !== 3'd1 || busy !== 1'b0) begin nFails++; $display("[TB] FAIL t1_count_busy: got %0d/%0b expected 1/0", res_count, busy); end
        applyStimulus(17'd0, 17'd0, 1'b0, 1'b0, 1'b0);
        nChecks++; if (res_valid !== 1'b1 || res_score0 !== 17'd100) begin
            nFails++; $display("[TB] FAIL t1_stall_hold: got %0b/%0d expected 1/100", res_valid, res_score0); end
        applyStimulus(17'd0, 17'd0, 1'b0, 1'b0, 1'b1);
        nChecks++; if (res_valid !== 1'b0 || res_count !== 3'd0) begin nFails++; $display("[TB] FAIL t1_pop: got %0b/%0d expected 0/0", res_valid, res_count); end
        nChecks++; if (res_score0 !== 17'd100) begin nFails++; $display("[TB] FAIL t1_last_hold: got %0d expected 100", res_score0); end
        applyStimulus(17'd0, 17'd0, 1'b0, 1'b0, 1'b1);
        nChecks++; if (res_count !== 3'd0) begin nFails++; $display("[TB] FAIL t1_empty_ready: got %0d expected 0", res_count); end
    endtask

    task automatic test_staggered;
        applyStimulus(17'd0, 17'h1FFFB, 1'b0, 1'b1, 1'b0);
        nChecks++; if (busy !== 1'b1) begin nFails++; $display("[TB] FAIL t2_busy0: got %0b expected 1", busy); end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(17'd0, 17'd0, 1'b0, 1'b0, 1'b0);
            nChecks++; if (busy !== 1'b1 || res_valid !== 1'b0) begin
                nFails++; $display("[TB] FAIL t2_busy_wait: got %0b/%0b expected 1/0", busy, res_valid); end
        end
        applyStimulus(17'h1FFF7, 17'd0, 1'b1, 1'b0, 1'b0);
        nChecks++; if (busy !== 1'b0 || res_valid !== 1'b1) begin nFails++; $display("[TB] FAIL t2_done: got %0b/%0b expected 0/1", busy, res_valid); end
        nChecks++; if (res_class !== 1'b1) begin nFails++; $display("[TB] FAIL t2_class: got %0b expected 1", res_class); end
        nChecks++; if (res_margin !== 18'h3FFFC) begin nFails++; $display("[TB] FAIL t2_margin: got %h expected 3fffc", res_margin); end
        nChecks++; if (res_score0 !== 17'h1FFF7 || res_score1 !== 17'h1FFFB) begin
            nFails++; $display("[TB] FAIL t2_scores: got %h/%h expected 1fff7/1fffb", res_score0, res_score1); end
        applyStimulus(17'd0, 17'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_timeout;
        applyStimulus(17'd7, 17'd0, 1'b1, 1'b0, 1'b0);
        repeat (63) applyStimulus(17'd0, 17'd0, 1'b0, 1'b0, 1'b0);
        nChecks++; if (busy !== 1'b1 || timeout_err !== 1'b0) begin
            nFails++; $display("[TB] FAIL t3_before: got %0b/%0b expected 1/0", busy, timeout_err); end
        applyStimulus(17'd0, 17'd0, 1'b0, 1'b0, 1'b0);
        nChecks++; if (timeout_err !== 1'b1 || busy !== 1'b0) begin
            nFails++; $display("[TB] FAIL t3_expire: got %0b/%0b expected 1/0", timeout_err, busy); end
        nChecks++; if (res_count !== 3'd0) begin nFails++; $display("[TB] FAIL t3_no_entry: got %0d expected 0", res_count); end
        clr_err = 1'b1;
        applyStimulus(17'd0, 17'd0, 1'b0, 1'b0, 1'b0);
        clr_err = 1'b0;
        nChecks++; if (timeout_err !== 1'b0) begin nFails++; $display("[TB] FAIL t3_clear: got %0b expected 0", timeout_err); end
        applyStimulus(17'd7, 17'd0, 1'b1, 1'b0, 1'b0);
        repeat (63) applyStimulus(17'd0, 17'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(17'd0, 17'd3, 1'b0, 1'b1, 1'b0);
        nChecks++; if (timeout_err !== 1'b0 || res_count !== 3'd1) begin
            nFails++; $display("[TB] FAIL t3_last_cycle_partner: got %0b/%0d expected 0/1", timeout_err, res_count); end
        nChecks++; if (res_margin !== 18'd4) begin nFails++; $display("[TB] FAIL t3_margin: got %h expected 4", res_margin); end
        applyStimulus(17'd0, 17'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(17'(10 + i), 17'(i), 1'b1, 1'b1, 1'b0);
            if (i == 3) begin
                nChecks++; if (overflow !== 1'b0) begin nFails++; $display("[TB] FAIL t4_not_yet: got %0b expected 0", overflow); end
            end
        end
        nChecks++; if (res_count !== 3'd4 || overflow !== 1'b1) begin
            nFails++; $display("[TB] FAIL t4_full: got %0d/%0b expected 4/1", res_count, overflow); end
        clr_err = 1'b1;
        applyStimulus(17'd99, 17'd99, 1'b1, 1'b1, 1'b0);
        nChecks++; if (overflow !== 1'b1) begin nFails++; $display("[TB] FAIL t4_err_beats_clear: got %0b expected 1", overflow); end
        applyStimulus(17'd0, 17'd0, 1'b0, 1'b0, 1'b0);
        clr_err = 1'b0;
        nChecks++; if (overflow !== 1'b0) begin nFails++; $display("[TB] FAIL t4_clear: got %0b expected 0", overflow); end
        for (int i = 0; i < 4; i++) begin
            nChecks++; if (res_score0 !== 17'(10 + i) || res_score1 !== 17'(i) || res_margin !== 18'd10) begin
                nFails++; $display("[TB] FAIL t4_drain%0d: got %0d/%0d/%0d expected %0d/%0d/10", i, res_score0, res_score1, res_margin, 10 + i, i); end
            applyStimulus(17'd0, 17'd0, 1'b0, 1'b0, 1'b1);
        end
        nChecks++; if (res_count !== 3'd0) begin nFails++; $display("[TB] FAIL t4_empty: got %0d expected 0", res_count); end
    endtask

    task automatic test_full_push_pop;
        logic [16:0] exp0 [4];
        logic [16:0] exp1 [4];
        exp0 = '{17'd21, 17'd22, 17'd23, 17'd50};
        exp1 = '{17'd1, 17'd2, 17'd3, 17'd60};
        for (int i = 0; i < 4; i++) applyStimulus(17'(20 + i), 17'(i), 1'b1, 1'b1, 1'b0);
        applyStimulus(17'd50, 17'd60, 1'b1, 1'b1, 1'b1);
        nChecks++; if (res_count !== 3'd4 || overflow !== 1'b0) begin
            nFails++; $display("[TB] FAIL t5_count: got %0d/%0b expected 4/0", res_count, overflow); end
        for (int i = 0; i < 4; i++) begin
            nChecks++; if (res_score0 !== exp0[i] || res_score1 !== exp1[i]) begin
                nFails++; $display("[TB] FAIL t5_order%0d: got %0d/%0d expected %0d/%0d", i, res_score0, res_score1, exp0[i], exp1[i]); end
            if (i == 3) begin
                nChecks++; if (res_class !== 1'b1 || res_margin !== 18'h3FFF6) begin
                    nFails++; $display("[TB] FAIL t5_tail: got %0b/%h expected 1/3fff6", res_class, res_margin); end
            end
            applyStimulus(17'd0, 17'd0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic test_tie_and_sign;
        applyStimulus(17'h1FFFF, 17'h1FFFF, 1'b1, 1'b1, 1'b0);
        nChecks++; if (res_class !== 1'b0 || res_margin !== 18'd0) begin
            nFails++; $display("[TB] FAIL t6_tie: got %0b/%h expected 0/0", res_class, res_margin); end
        applyStimulus(17'd0, 17'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(17'h1FFFF, 17'd1, 1'b1, 1'b1, 1'b0);
        nChecks++; if (res_class !== 1'b1 || res_margin !== 18'h3FFFE) begin
            nFails++; $display("[TB] FAIL t6_signed: got %0b/%h expected 1/3fffe", res_class, res_margin); end
        applyStimulus(17'd0, 17'd0, 1'b0, 1'b0, 1'b1);
        uOut0 = 17'h1FFFF; uOut1 = 17'd1; uOut0Ready = 1'b1; uOut1Ready = 1'b1;
        @(posedge clk); #1;
        uOut0Ready = 1'b0; uOut1Ready = 1'b0;
        nChecks++; if (uValid !== 1'b1 || uClass !== 1'b0 || uMargin !== 18'h1FFFE) begin
            nFails++; $display("[TB] FAIL t6_unsigned: got %0b/%0b/%h expected 1/0/1fffe", uValid, uClass, uMargin); end
    endtask

    task automatic test_back_to_back;
        logic [16:0] exp0 [3];
        logic [16:0] exp1 [3];
        exp0 = '{17'd8, 17'd1, 17'd30};
        exp1 = '{17'd2, 17'd4, 17'd10};
        applyStimulus(17'd5, 17'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(17'd8, 17'd0, 1'b1, 1'b0, 1'b0);
        nChecks++; if (busy !== 1'b1 || res_count !== 3'd0) begin nFails++; $display("[TB] FAIL bb_overwrite: got %0b/%0d expected 1/0", busy, res_count); end
        applyStimulus(17'd0, 17'd2, 1'b0, 1'b1, 1'b0);
        applyStimulus(17'd1, 17'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(17'd30, 17'd4, 1'b1, 1'b1, 1'b0);
        nChecks++; if (busy !== 1'b1 || res_count !== 3'd2) begin nFails++; $display("[TB] FAIL bb_restart: got %0b/%0d expected 1/2", busy, res_count); end
        applyStimulus(17'd0, 17'd10, 1'b0, 1'b1, 1'b0);
        nChecks++; if (busy !== 1'b0 || res_count !== 3'd3) begin nFails++; $display("[TB] FAIL bb_complete: got %0b/%0d expected 0/3", busy, res_count); end
        for (int i = 0; i < 3; i++) begin
            nChecks++; if (res_score0 !== exp0[i] || res_score1 !== exp1[i]) begin
                nFails++; $display("[TB] FAIL bb_order%0d: got %0d/%0d expected %0d/%0d", i, res_score0, res_score1, exp0[i], exp1[i]); end
            if (i == 1) begin
                nChecks++; if (res_class !== 1'b1 || res_margin !== 18'h3FFFD) begin
                    nFails++; $display("[TB] FAIL bb_class: got %0b/%h expected 1/3fffd", res_class, res_margin); end
            end
            applyStimulus(17'd0, 17'd0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic test_reset_mid;
        applyStimulus(17'd11, 17'd12, 1'b1, 1'b1, 1'b0);
        applyStimulus(17'd13, 17'd0, 1'b1, 1'b0, 1'b0);
        nChecks++; if (busy !== 1'b1 || res_count !== 3'd1) begin nFails++; $display("[TB] FAIL rm_setup: got %0b/%0d expected 1/1", busy, res_count); end
        rst_n = 1'b0;
        #2;
        nChecks++; if (busy !== 1'b0 || res_count !== 3'd0 || res_valid !== 1'b0) begin
            nFails++; $display("[TB] FAIL rm_cleared: got %0b/%0d/%0b expected 0/0/0", busy, res_count, res_valid); end
        nChecks++; if (res_score0 !== 17'd0 || {timeout_err, overflow} !== 2'b00) begin
            nFails++; $display("[TB] FAIL rm_data_flags: got %0d/%b expected 0/00", res_score0, {timeout_err, overflow}); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        out0 = '0; out1 = '0; out0_ready = 1'b0; out1_ready = 1'b0;
        res_ready = 1'b0; clr_err = 1'b0;
        uOut0 = '0; uOut1 = '0; uOut0Ready = 1'b0; uOut1Ready = 1'b0;
        test_reset();
        test_same_cycle();
        test_staggered();
        test_timeout();
        test_overflow();
        test_full_push_pop();
        test_tie_and_sign();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
